// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N-to-1 valid/ready multiplexer feeding a single-entry registered output.
// Define MUXN_ROUNDROBIN_EN to add the RR port and a round-robin arbitration mode.
module mux_nto1_reg #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  A,
    input  logic [N-1:0]    AV,
    output logic [N-1:0]    AR,
    input  logic [SELW-1:0] SEL,
    output logic [W-1:0]    Y,
    output logic            YV,
    input  logic            YR,
    output logic [SELW-1:0] GNT
`ifdef MUXN_ROUNDROBIN_EN
    ,
    input  logic            RR
`endif
);

    logic [W-1:0]    ch [N];
    logic [SELW-1:0] c;
    logic            c_valid;
    logic            sel_ok;
    logic            load;
    logic            xfer;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ch[g] = A[g*W +: W];
    end

    // Select values at or beyond N address no channel.
    assign sel_ok = int'(SEL) < N;

`ifdef MUXN_ROUNDROBIN_EN
    logic [SELW-1:0] p;
    logic [SELW-1:0] c_rr;
    logic            rr_found;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        c_rr     = p;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found && AV[(int'(p) + k) % N]) begin
                rr_found = 1'b1;
                c_rr     = SELW'((int'(p) + k) % N);
            end
        end
    end

    assign c       = RR ? c_rr : SEL;
    assign c_valid = RR ? rr_found : sel_ok;
`else
    assign c       = SEL;
    assign c_valid = sel_ok;
`endif

    // The register accepts when empty or when its current beat drains this cycle.
    assign load = !RST && (!YV || YR);
    assign AR   = (load && c_valid) ? (N'(1) << c) : '0;
    assign xfer = load && c_valid && AV[c];

    // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Y   <= '0;
            YV  <= 1'b0;
            GNT <= '0;
`ifdef MUXN_ROUNDROBIN_EN
            p   <= SELW'(N - 1);
`endif
        end else if (xfer) begin
            Y   <= ch[c];
            YV  <= 1'b1;
            GNT <= c;
`ifdef MUXN_ROUNDROBIN_EN
            if (RR) p <= c;
`endif
        end else if (YR) begin
            YV  <= 1'b0;
        end
    end

endmodule

// File: doc/mux_nto1_reg.md
MUX_NTO1_REG -- requirements
Module: mux_nto1_reg

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of input channels (legal range 2..16).
REQ-002 SHALL have parameter W, default 8, meaning data width per channel.
REQ-003 SHALL have localparam SELW = clog2(N), minimum 1, meaning the width of the select and grant fields.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 A  input  N*W  flattened channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-008 AV  input  N  per-channel valid.
REQ-009 AR  output  N  per-channel ready, combinational.
REQ-010 SEL  input  SELW  channel select.
REQ-011 Y  output  W  registered output data.
REQ-012 YV  output  1  output valid.
REQ-013 YR  input  1  downstream ready.
REQ-014 GNT  output  SELW  index of the channel whose data is in Y.
REQ-015 RR  input  1  arbitration mode; this port is present only when MUXN_ROUNDROBIN_EN is defined.

Function
REQ-016 SHALL hold a single-entry output register (Y, YV, GNT).
REQ-017 SHALL compute the selected channel c combinationally; in select mode c = SEL.
REQ-018 SHALL define load = !RST & (!YV | YR), so the register can accept when empty or draining in the same cycle.
REQ-019 SHALL drive AR[i] = load & (i == c) & c-valid; all other AR bits are 0.
REQ-020 SHALL treat a transfer as AV[c] & AR[c], after which at the next edge Y = A[c], YV = 1 and GNT = c (latency 1 cycle).
REQ-021 SHALL sustain 1 beat per cycle when YR is held at 1.
REQ-022 SHALL clear YV at the edge when YV & YR & no transfer occurs; Y and GNT keep their last values.
REQ-023 SHALL keep Y and GNT stable while YV & !YR, regardless of changes on SEL, AV or A.
REQ-024 SHALL treat SEL >= N as no channel selected: c-valid = 0, AR = 0, no transfer.
REQ-025 SHALL allow AV to drop without a transfer; no data is latched in that case.
REQ-026 SHALL ignore AV of non-selected channels.

Reset
REQ-027 SHALL, on RST high at a clock edge, set YV = 0, Y = 0, GNT = 0 and the round-robin pointer P = N-1.
REQ-028 SHALL hold AR = 0 while RST = 1.
REQ-029 SHALL discard any held beat when reset is asserted mid-hold.

Configuration
REQ-030 SHALL provide macro MUXN_ROUNDROBIN_EN.
REQ-031 With the macro defined: port RR exists; RR = 0 selects select mode; RR = 1 selects round-robin mode, in which SEL is ignored.
REQ-032 In round-robin mode, c SHALL be the first i with AV[i] = 1, searching P+1, P+2, ... wrapping modulo N and ending at P; c-valid = |AV.
REQ-033 SHALL update P = c on each transfer and leave P unchanged otherwise; P is not changed while RR = 0.
REQ-034 Without the macro: RR and P SHALL be absent and behaviour SHALL be select mode only.

Verification (N=4, W=8 unless stated)
REQ-035 Reset: RST=1 for 2 cycles with AV=1111 -> AR=0000, YV=0, Y=0x00, GNT=0.
REQ-036 Streaming: SEL=2, AV=0100, A2 = 0x5A, 0x5B, 0x5C on consecutive cycles, YR=1 -> Y = 0x5A, 0x5B, 0x5C one cycle later each, GNT=2, YV=1 continuously.
REQ-037 Backpressure: YV=1 (Y=0x11), YR=0 for 3 cycles while SEL/A change -> AR=0000 and Y=0x11 held; YR=1 -> new beat loaded at the same edge.
REQ-038 Invalid select: N=6 instance, SEL=7, AV=all 1 -> AR=000000, YV stays 0.
REQ-039 Round-robin (macro on, RR=1, YR=1): AV=1111 from reset -> GNT sequence 0,1,2,3,0; then AV=1010 -> 1,3,1,3.
REQ-040 Reset mid-hold: YV=1, YR=0, 1-cycle RST pulse -> YV=0 after the edge; the next transfer loads fresh data and, in round-robin mode, grants channel 0 first.
